// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for uart_rx.
// Holds the clocks-per-bit register and captures completed bytes into a
// first-word-fall-through FIFO. It also tracks overrun, runs an idle-timeout
// FSM and raises a registered level/timeout/overrun interrupt.
module uart_rx_ctrl #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] CPB_RESET = 16'd868,
  parameter int          TO_BITS   = 40,
  localparam int         LW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [15:0]   cfg_cpb,
  input  logic          rx_en,
  output logic [15:0]   uart_cpb,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [LW-1:0] level,
  output logic          full,
  input  logic [LW-1:0] thresh,
  output logic          overrun,
  input  logic          ovr_clr,
  output logic          timeout,
  output logic          irq
);

  localparam int PW = LW - 1;
  localparam int TW = $clog2(TO_BITS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_BITS - 1);

  localparam logic [1:0] T_IDLE    = 2'd0;
  localparam logic [1:0] T_COUNT   = 2'd1;
  localparam logic [1:0] T_EXPIRED = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          rx_done_q;
  logic          push_req;
  logic          pop_req;
  logic          do_push;
  logic          drop;
  logic          activity;
  logic [1:0]    state;
  logic [15:0]   bit_cnt;
  logic [TW-1:0] tick_cnt;

  // CPB register: values below 16 are rejected, previous value kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_cpb <= CPB_RESET;
    end else if (cfg_we && (cfg_cpb >= 16'd16)) begin
      uart_cpb <= cfg_cpb;
    end
  end

  // rx_done edge history; resets high so a level already high is not a push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q <= 1'b1;
    end else begin
      rx_done_q <= rx_done;
    end
  end

  assign full     = (level == LW'(DEPTH));
  assign rd_valid = (level != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Push/pop qualification; a pop frees the slot a full-FIFO push needs
  always_comb begin
    push_req = rx_en && rx_done && !rx_done_q;
    pop_req  = rd_en && rd_valid;
    do_push  = push_req && (!full || pop_req);
    drop     = push_req && full && !pop_req;
    activity = do_push || pop_req;
    unique case ({do_push, pop_req})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // FIFO storage; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy held separately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_req) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
    end
  end

  // Sticky overrun; a same-cycle set beats the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  // Idle-timeout FSM with bit-period prescaler and tick counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= T_IDLE;
      bit_cnt  <= '0;
      tick_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        T_IDLE: begin
          bit_cnt  <= '0;
          tick_cnt <= '0;
          if (level_nxt != '0) state <= T_COUNT;
        end
        T_COUNT: begin
          if (level_nxt == '0) begin
            state    <= T_IDLE;
            bit_cnt  <= '0;
            tick_cnt <= '0;
          end else if (activity) begin
            bit_cnt  <= '0;
            tick_cnt <= '0;
          end else if (bit_cnt >= uart_cpb) begin
            // >= keeps the prescaler sane if uart_cpb shrinks mid-count
            bit_cnt <= '0;
            if (tick_cnt == TO_LAST) begin
              state    <= T_EXPIRED;
              timeout  <= 1'b1;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        T_EXPIRED: begin
          bit_cnt  <= '0;
          tick_cnt <= '0;
          if (activity) begin
            timeout <= 1'b0;
            state   <= (level_nxt == '0) ? T_IDLE : T_COUNT;
          end
        end
        default: begin
          state    <= T_IDLE;
          bit_cnt  <= '0;
          tick_cnt <= '0;
          timeout  <= 1'b0;
        end
      endcase
    end
  end

  // Registered interrupt from the already-registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= ((thresh != '0) && (level >= thresh)) || timeout || overrun;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a byte scoreboard queue.
module tb_uart_rx_ctrl;

  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [15:0]   cfg_cpb;
  logic          rx_en;
  logic [15:0]   uart_cpb;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          full;
  logic [LW-1:0] thresh;
  logic          overrun;
  logic          ovr_clr;
  logic          timeout;
  logic          irq;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int mlevel = 0;
  logic [7:0] sb[$];

  uart_rx_ctrl #(.DEPTH(8), .CPB_RESET(16'd868), .TO_BITS(40)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_cpb(cfg_cpb), .rx_en(rx_en),
    .uart_cpb(uart_cpb), .rx_data(rx_data), .rx_done(rx_done), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .full(full),
    .thresh(thresh), .overrun(overrun), .ovr_clr(ovr_clr), .timeout(timeout),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One rx_done pulse; the scoreboard records what the FIFO should accept.
  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    if (rx_en) begin
      if (mlevel < 8) begin
        sb.push_back(b);
        mlevel++;
      end
    end
    step();
    rx_done = 1'b0;
    step();
  endtask

  // Pop the head and compare against the scoreboard front.
  task automatic pop_byte();
    logic [7:0] exp_b;
    exp_b = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    total++;
    if (rd_data !== exp_b || rd_valid !== 1'b1) begin
      $display("FAIL pop_data: got %h valid %b, want %h valid 1", rd_data, rd_valid, exp_b);
    end else passed++;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    if (mlevel > 0) mlevel--;
  endtask

  task automatic test_reset();
    total++; if (uart_cpb !== 16'd868) $display("FAIL reset_cpb: got %0d want 868", uart_cpb); else passed++;
    total++; if (level !== 4'd0 || rd_valid !== 1'b0 || full !== 1'b0)
      $display("FAIL reset_fifo: level %0d valid %b full %b, want 0 0 0", level, rd_valid, full); else passed++;
    total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else passed++;
    total++; if (overrun !== 1'b0 || timeout !== 1'b0 || irq !== 1'b0)
      $display("FAIL reset_flags: ovr %b to %b irq %b, want 0 0 0", overrun, timeout, irq); else passed++;
  endtask

  task automatic test_cpb();
    cfg_cpb = 16'd10; cfg_we = 1'b1; step(); cfg_we = 1'b0;
    total++; if (uart_cpb !== 16'd868) $display("FAIL cpb_reject: got %0d want 868", uart_cpb); else passed++;
    cfg_cpb = 16'd434; cfg_we = 1'b1; step(); cfg_we = 1'b0;
    total++; if (uart_cpb !== 16'd434) $display("FAIL cpb_load: got %0d want 434", uart_cpb); else passed++;
    cfg_cpb = 16'd16; cfg_we = 1'b1; step(); cfg_we = 1'b0;
    total++; if (uart_cpb !== 16'd16) $display("FAIL cpb_min: got %0d want 16", uart_cpb); else passed++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    total++; if (level !== 4'd8 || full !== 1'b1)
      $display("FAIL fill_level: level %0d full %b, want 8 1", level, full); else passed++;
    for (int i = 0; i < 8; i++) pop_byte();
    total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || level !== 4'd0)
      $display("FAIL drain_empty: valid %b data %h level %0d, want 0 00 0", rd_valid, rd_data, level); else passed++;
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) push_byte(8'h11 + 8'(i));
    rx_data = 8'hAA; rx_done = 1'b1; step(); rx_done = 1'b0;
    total++; if (overrun !== 1'b1 || level !== 4'd8)
      $display("FAIL ovr_set: ovr %b level %0d, want 1 8", overrun, level); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL ovr_irq_early: got %b want 0", irq); else passed++;
    step();
    total++; if (irq !== 1'b1) $display("FAIL ovr_irq: got %b want 1", irq); else passed++;
    rx_data = 8'hBB; rx_done = 1'b1; ovr_clr = 1'b1; step(); rx_done = 1'b0; ovr_clr = 1'b0;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins: got %b want 1", overrun); else passed++;
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clr: got %b want 0", overrun); else passed++;
    for (int i = 0; i < 8; i++) pop_byte();
    step();
    total++; if (irq !== 1'b0 || level !== 4'd0)
      $display("FAIL ovr_after: irq %b level %0d, want 0 0", irq, level); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_b;
    for (int i = 0; i < 8; i++) push_byte(8'h21 + 8'(i));
    exp_b = sb.pop_front();
    sb.push_back(8'h55);
    total++; if (rd_data !== exp_b) $display("FAIL simfull_head: got %h want %h", rd_data, exp_b); else passed++;
    rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1; step(); rx_done = 1'b0; rd_en = 1'b0;
    total++; if (level !== 4'd8 || overrun !== 1'b0)
      $display("FAIL simfull_level: level %0d ovr %b, want 8 0", level, overrun); else passed++;
    step();
    for (int i = 0; i < 8; i++) pop_byte();
    rx_data = 8'h66; rx_done = 1'b1; rd_en = 1'b1; step(); rx_done = 1'b0; rd_en = 1'b0;
    sb.push_back(8'h66); mlevel = 1;
    total++; if (level !== 4'd1) $display("FAIL simempty_level: got %0d want 1", level); else passed++;
    step();
    pop_byte();
  endtask

  task automatic test_threshold();
    thresh = 4'd4;
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
    step();
    total++; if (irq !== 1'b0) $display("FAIL thresh_below: got %b want 0", irq); else passed++;
    push_byte(8'h33);
    total++; if (irq !== 1'b1) $display("FAIL thresh_hit: got %b want 1", irq); else passed++;
    for (int i = 0; i < 4; i++) pop_byte();
    thresh = 4'd0;
    step();
  endtask

  task automatic test_timeout();
    int t0;
    int elapsed;
    bit seen;
    rx_data = 8'h44; rx_done = 1'b1; sb.push_back(8'h44); mlevel++;
    step(); rx_done = 1'b0;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (timeout === 1'b1) seen = 1'b1; else step();
    end
    elapsed = cyc - t0;
    total++; if (!seen || elapsed < 678 || elapsed > 683)
      $display("FAIL timeout_latency: seen %b after %0d cycles, want 1 near 680", seen, elapsed); else passed++;
    step();
    total++; if (irq !== 1'b1) $display("FAIL timeout_irq: got %b want 1", irq); else passed++;
    pop_byte();
    total++; if (timeout !== 1'b0 || level !== 4'd0)
      $display("FAIL timeout_clear: to %b level %0d, want 0 0", timeout, level); else passed++;
    repeat (800) step();
    total++; if (timeout !== 1'b0 || irq !== 1'b0)
      $display("FAIL timeout_idle: to %b irq %b, want 0 0", timeout, irq); else passed++;
  endtask

  task automatic test_disable();
    rx_en = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i));
    total++; if (level !== 4'd0 || overrun !== 1'b0)
      $display("FAIL disable: level %0d ovr %b, want 0 0", level, overrun); else passed++;
    rx_en = 1'b1;
  endtask

  task automatic test_sticky_reset();
    push_byte(8'h99);
    #2 rst = 1'b1; rx_done = 1'b1;
    #1;
    sb.delete(); mlevel = 0;
    total++; if (level !== 4'd0 || rd_valid !== 1'b0 || uart_cpb !== 16'd868)
      $display("FAIL async_rst: level %0d valid %b cpb %0d, want 0 0 868", level, rd_valid, uart_cpb); else passed++;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    total++; if (level !== 4'd0) $display("FAIL sticky_high: got %0d want 0", level); else passed++;
    rx_done = 1'b0; step();
    push_byte(8'h77);
    total++; if (level !== 4'd1 || rd_data !== 8'h77)
      $display("FAIL sticky_refire: level %0d data %h, want 1 77", level, rd_data); else passed++;
    pop_byte();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_cpb = '0; rx_en = 1'b1; rx_data = '0;
    rx_done = 1'b0; rd_en = 1'b0; thresh = '0; ovr_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    test_reset();
    test_cpb();
    test_fill_drain();
    test_overrun();
    test_simultaneous();
    test_threshold();
    test_timeout();
    test_disable();
    test_sticky_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
